// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sharing one combinational alu (optional ALU_ARB_PERF_EN counters)

// Combinational ALU; opcode is {funct7[5], funct3}
module alu #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_op1,
   input  logic [XLEN-1:0] i_op2,
   input  logic [3:0]      i_alu_op,
   output logic [XLEN-1:0] o_result
);

   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0] shamt;
   assign shamt = i_op2[SHW-1:0];

   // Decode the opcode into one result
   always_comb begin
      o_result = '0;
      case (i_alu_op)
         4'b0000: o_result = i_op1 + i_op2;
         4'b1000: o_result = i_op1 - i_op2;
         4'b0001: o_result = i_op1 << shamt;
         4'b0010: o_result = {{(XLEN-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
         4'b0011: o_result = {{(XLEN-1){1'b0}}, (i_op1 < i_op2)};
         4'b0100: o_result = i_op1 ^ i_op2;
         4'b0101: o_result = i_op1 >> shamt;
         4'b1101: o_result = $unsigned($signed(i_op1) >>> shamt);
         4'b0110: o_result = i_op1 | i_op2;
         4'b0111: o_result = i_op1 & i_op2;
         default: o_result = '0;
      endcase
   end

endmodule

// Arbiter: one issue per cycle, result registered per port
module alu_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req0_valid,
   output logic            o_req0_ready,
   input  logic [XLEN-1:0] i_req0_op1,
   input  logic [XLEN-1:0] i_req0_op2,
   input  logic [3:0]      i_req0_alu_op,
   input  logic            i_req1_valid,
   output logic            o_req1_ready,
   input  logic [XLEN-1:0] i_req1_op1,
   input  logic [XLEN-1:0] i_req1_op2,
   input  logic [3:0]      i_req1_alu_op,
   output logic            o_rsp0_valid,
   output logic [XLEN-1:0] o_rsp0_result,
   input  logic            i_rsp0_ready,
   output logic            o_rsp1_valid,
   output logic [XLEN-1:0] o_rsp1_result,
   input  logic            i_rsp1_ready,
`ifdef ALU_ARB_PERF_EN
   output logic [31:0]     o_grant0_cnt,
   output logic [31:0]     o_grant1_cnt,
   output logic [31:0]     o_conflict_cnt,
`endif
   output logic            o_busy
);

   logic            elig0, elig1;
   logic            grant0, grant1;
   logic            last_grant;
   logic [XLEN-1:0] alu_op1, alu_op2, alu_result;
   logic [3:0]      alu_opc;

   // A port is eligible only if its response slot is free or draining now
   assign elig0 = i_req0_valid & (~o_rsp0_valid | i_rsp0_ready);
   assign elig1 = i_req1_valid & (~o_rsp1_valid | i_rsp1_ready);

   // On a tie, the port that did not win last time goes first
   assign grant0 = elig0 & (~elig1 | last_grant);
   assign grant1 = elig1 & ~grant0;

   assign o_req0_ready = grant0 & ~i_rst;
   assign o_req1_ready = grant1 & ~i_rst;
   assign o_busy       = o_rsp0_valid | o_rsp1_valid;

   // Steer the granted port's operands to the shared alu (port 0 when idle)
   always_comb begin
      alu_op1 = i_req0_op1;
      alu_op2 = i_req0_op2;
      alu_opc = i_req0_alu_op;
      if (grant1) begin
         alu_op1 = i_req1_op1;
         alu_op2 = i_req1_op2;
         alu_opc = i_req1_alu_op;
      end
   end

   alu #(.XLEN(XLEN)) u_alu (
      .i_op1    (alu_op1),
      .i_op2    (alu_op2),
      .i_alu_op (alu_opc),
      .o_result (alu_result)
   );

   // Capture results on accept, drop valid on drain, remember the last winner
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rsp0_valid  <= 1'b0;
         o_rsp0_result <= '0;
         o_rsp1_valid  <= 1'b0;
         o_rsp1_result <= '0;
         last_grant    <= 1'b1;
      end else begin
         if (o_req0_ready) begin
            o_rsp0_valid  <= 1'b1;
            o_rsp0_result <= alu_result;
            last_grant    <= 1'b0;
         end else if (o_rsp0_valid && i_rsp0_ready) begin
            o_rsp0_valid  <= 1'b0;
         end
         if (o_req1_ready) begin
            o_rsp1_valid  <= 1'b1;
            o_rsp1_result <= alu_result;
            last_grant    <= 1'b1;
         end else if (o_rsp1_valid && i_rsp1_ready) begin
            o_rsp1_valid  <= 1'b0;
         end
      end
   end

`ifdef ALU_ARB_PERF_EN
   // Free-running event counters, wrapping naturally at 32 bits
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_grant0_cnt   <= '0;
         o_grant1_cnt   <= '0;
         o_conflict_cnt <= '0;
      end else begin
         if (o_req0_ready) o_grant0_cnt <= o_grant0_cnt + 32'd1;
         if (o_req1_ready) o_grant1_cnt <= o_grant1_cnt + 32'd1;
         if (elig0 && elig1) o_conflict_cnt <= o_conflict_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter

module tb_alu_arbiter;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            req0_valid, req1_valid;
   logic            req0_ready, req1_ready;
   logic [XLEN-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic [3:0]      req0_alu_op, req1_alu_op;
   logic            rsp0_valid, rsp1_valid;
   logic [XLEN-1:0] rsp0_result, rsp1_result;
   logic            rsp0_ready, rsp1_ready;
   logic            busy;
`ifdef ALU_ARB_PERF_EN
   logic [31:0]     grant0_cnt, grant1_cnt, conflict_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.XLEN(XLEN)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_req0_valid  (req0_valid),
      .o_req0_ready  (req0_ready),
      .i_req0_op1    (req0_op1),
      .i_req0_op2    (req0_op2),
      .i_req0_alu_op (req0_alu_op),
      .i_req1_valid  (req1_valid),
      .o_req1_ready  (req1_ready),
      .i_req1_op1    (req1_op1),
      .i_req1_op2    (req1_op2),
      .i_req1_alu_op (req1_alu_op),
      .o_rsp0_valid  (rsp0_valid),
      .o_rsp0_result (rsp0_result),
      .i_rsp0_ready  (rsp0_ready),
      .o_rsp1_valid  (rsp1_valid),
      .o_rsp1_result (rsp1_result),
      .i_rsp1_ready  (rsp1_ready),
`ifdef ALU_ARB_PERF_EN
      .o_grant0_cnt  (grant0_cnt),
      .o_grant1_cnt  (grant1_cnt),
      .o_conflict_cnt(conflict_cnt),
`endif
      .o_busy        (busy)
   );

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b1; req0_op1 = 32'd10; req0_op2 = 32'd5; req0_alu_op = 4'b0000;
      req1_valid = 1'b1; req1_op1 = 32'd7;  req1_op2 = 32'd1; req1_alu_op = 4'b0000;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready0 c%0d: got %b want 0", i, req0_ready); end
         vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready1 c%0d: got %b want 0", i, req1_ready); end
         vectors++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_valid c%0d: got %b%b%b want 000", i, rsp0_valid, rsp1_valid, busy); end
         vectors++; if (rsp0_result !== 32'd0 || rsp1_result !== 32'd0) begin miscompares++; $display("FAIL reset_result c%0d: got %0d/%0d want 0/0", i, rsp0_result, rsp1_result); end
`ifdef ALU_ARB_PERF_EN
         vectors++; if (grant0_cnt !== 0 || grant1_cnt !== 0 || conflict_cnt !== 0) begin miscompares++; $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", grant0_cnt, grant1_cnt, conflict_cnt); end
`endif
      end
      rst = 1'b0;
      #1;
      vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_first_grant: got %b%b want 10", req0_ready, req1_ready); end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_single_add();
      do_reset();
      req0_valid = 1'b1; req0_op1 = 32'd10; req0_op2 = 32'd5; req0_alu_op = 4'b0000;
      #1;
      vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL add_ready: got %b%b want 10", req0_ready, req1_ready); end
      step();
      req0_valid = 1'b0;
      vectors++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd15) begin miscompares++; $display("FAIL add_rsp0: got v=%b r=%0d want v=1 r=15", rsp0_valid, rsp0_result); end
      vectors++; if (rsp1_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL add_rsp1_busy: got %b%b want 01", rsp1_valid, busy); end
      step();
      vectors++; if (rsp0_valid !== 1'b0 || rsp0_result !== 32'd15 || busy !== 1'b0) begin miscompares++; $display("FAIL add_drain: got v=%b r=%0d b=%b want v=0 r=15 b=0", rsp0_valid, rsp0_result, busy); end
   endtask

   task automatic test_contention();
      do_reset();
      req0_valid = 1'b1; req0_op1 = 32'd10; req0_op2 = 32'd5;  req0_alu_op = 4'b1000;
      req1_valid = 1'b1; req1_op1 = 32'd5;  req1_op2 = 32'd10; req1_alu_op = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         #1;
         vectors++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin miscompares++; $display("FAIL cont_grant c%0d: got %b%b want %b%b", i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1)); end
         vectors++; if (rsp0_valid !== (i % 2 == 1) || (rsp0_valid && rsp0_result !== 32'd5)) begin miscompares++; $display("FAIL cont_rsp0 c%0d: got v=%b r=%0d want v=%b r=5", i, rsp0_valid, rsp0_result, (i % 2 == 1)); end
         vectors++; if (rsp1_valid !== (i > 0 && i % 2 == 0) || (rsp1_valid && rsp1_result !== 32'd1)) begin miscompares++; $display("FAIL cont_rsp1 c%0d: got v=%b r=%0d want v=%b r=1", i, rsp1_valid, rsp1_result, (i > 0 && i % 2 == 0)); end
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_op1 = 32'd10; req0_op2 = 32'd5; req0_alu_op = 4'b0000;
      req1_valid = 1'b1; req1_op1 = 32'd7;  req1_op2 = 32'd1; req1_alu_op = 4'b0000;
      #1;
      vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL bp_first: got %b%b want 10", req0_ready, req1_ready); end
      step();
      req0_op1 = 32'd20; req0_op2 = 32'd3;
      for (int i = 1; i < 4; i++) begin
         #1;
         vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin miscompares++; $display("FAIL bp_grant c%0d: got %b%b want 01", i, req0_ready, req1_ready); end
         vectors++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd15) begin miscompares++; $display("FAIL bp_hold c%0d: got v=%b r=%0d want v=1 r=15", i, rsp0_valid, rsp0_result); end
         if (i > 1) begin
            vectors++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd8) begin miscompares++; $display("FAIL bp_rsp1 c%0d: got v=%b r=%0d want v=1 r=8", i, rsp1_valid, rsp1_result); end
         end
         step();
      end
      rsp0_ready = 1'b1;
      #1;
      vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %b%b want 10", req0_ready, req1_ready); end
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      vectors++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd23) begin miscompares++; $display("FAIL bp_overwrite: got v=%b r=%0d want v=1 r=23", rsp0_valid, rsp0_result); end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      req1_valid = 1'b1; req1_op1 = 32'd7; req1_op2 = 32'd1; req1_alu_op = 4'b0000;
      #1;
      vectors++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin miscompares++; $display("FAIL mid_accept: got %b%b want 01", req0_ready, req1_ready); end
      step();
      req1_valid = 1'b0;
      rst = 1'b1;
      vectors++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd8) begin miscompares++; $display("FAIL mid_rsp1: got v=%b r=%0d want v=1 r=8", rsp1_valid, rsp1_result); end
      step();
      rst = 1'b0;
      vectors++; if (rsp1_valid !== 1'b0 || rsp1_result !== 32'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_flush: got v=%b r=%0d b=%b want v=0 r=0 b=0", rsp1_valid, rsp1_result, busy); end
      step();
      vectors++; if (rsp1_valid !== 1'b0 || rsp0_valid !== 1'b0) begin miscompares++; $display("FAIL mid_after: got %b%b want 00", rsp0_valid, rsp1_valid); end
   endtask

`ifdef ALU_ARB_PERF_EN
   task automatic test_perf();
      do_reset();
      req0_valid = 1'b1; req0_op1 = 32'd1; req0_op2 = 32'd2; req0_alu_op = 4'b0000;
      req1_valid = 1'b1; req1_op1 = 32'd3; req1_op2 = 32'd4; req1_alu_op = 4'b0000;
      for (int i = 0; i < 4; i++) step();
      req0_valid = 1'b0;
      for (int i = 0; i < 2; i++) step();
      req1_valid = 1'b0;
      vectors++; if (grant0_cnt !== 32'd2) begin miscompares++; $display("FAIL perf_g0: got %0d want 2", grant0_cnt); end
      vectors++; if (grant1_cnt !== 32'd4) begin miscompares++; $display("FAIL perf_g1: got %0d want 4", grant1_cnt); end
      vectors++; if (conflict_cnt !== 32'd4) begin miscompares++; $display("FAIL perf_conflict: got %0d want 4", conflict_cnt); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_op1 = '0; req0_op2 = '0; req0_alu_op = '0;
      req1_op1 = '0; req1_op2 = '0; req1_alu_op = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      step();
      test_reset();
      test_single_add();
      test_contention();
      test_backpressure();
      test_reset_midflight();
`ifdef ALU_ARB_PERF_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance between two independent requesters, e.g. the execute stage (port 0) and the branch/address unit (port 1).
- Each port has a valid/ready request channel and a registered valid/ready response channel.
- Arbitration is round-robin on conflict. At most one ALU operation is issued per cycle, with 1-cycle latency from accept to response valid.

Parameters:
- XLEN, 32, operand/result width; must match the instantiated `alu`.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_req0_valid  in  1  port 0 request valid.
- o_req0_ready  out  1  port 0 request accepted this cycle.
- i_req0_op1  in  XLEN  port 0 operand 1.
- i_req0_op2  in  XLEN  port 0 operand 2.
- i_req0_alu_op  in  4  port 0 ALU opcode; passed unchanged to the `alu` i_alu_op.
- i_req1_valid, o_req1_ready, i_req1_op1, i_req1_op2, i_req1_alu_op: same as port 0, for port 1.
- o_rsp0_valid  out  1  port 0 result valid.
- o_rsp0_result  out  XLEN  port 0 result.
- i_rsp0_ready  in  1  port 0 consumer accepts the result.
- o_rsp1_valid, o_rsp1_result, i_rsp1_ready: same as port 0, for port 1.
- o_busy  out  1  high when any o_rspN_valid is high.

Behaviour:
- Reset (i_rst=1 at an edge):
  - o_rspN_valid=0, o_rspN_result=0, o_busy=0.
  - Round-robin pointer last_grant=1, so port 0 wins the first tie.
  - Optional counters cleared.
  - While i_rst=1: o_reqN_ready=0 combinationally, and no accept occurs.
  - Reset mid-operation discards pending results without further handshakes.
- Eligibility: eligN = i_reqN_valid & (!o_rspN_valid | i_rspN_ready). A port whose response slot is occupied and not being drained this cycle cannot be granted.
- Grant (combinational):
  - Only one port eligible: grant it.
  - Both eligible: grant the port != last_grant.
  - o_reqN_ready = grantN & !i_rst. Never assert both readies in one cycle.
  - Ready must not depend on the requester's operand values. It may depend on i_reqN_valid.
- ALU mux: the granted port's op1/op2/alu_op drive the `alu` instance. With no grant, drive port 0's inputs; the result is ignored.
- On accept of port N at edge k:
  - o_rspN_result <= alu o_result and o_rspN_valid <= 1, visible in cycle k+1.
  - last_grant <= N. last_grant updates only on an accept.
- Response drain: if o_rspN_valid & i_rspN_ready and no new accept for N, then o_rspN_valid <= 0. o_rspN_result holds its value.
- Simultaneous drain and accept on the same port (eligibility permits it): the new result overwrites and valid stays 1. Full throughput is 1 op/cycle per port when uncontested.
- Response stability: while o_rspN_valid=1 & i_rspN_ready=0, o_rspN_result is held constant.
- Requester rules: a requester holds valid and operands stable until ready. The arbiter does not check this.
- Starvation: with both ports continuously eligible, grants alternate 0,1,0,1…
- Width: results are XLEN wide, truncation is as performed by `alu`, and the arbiter performs no arithmetic.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined: adds outputs o_grant0_cnt[31:0], o_grant1_cnt[31:0] and o_conflict_cnt[31:0].
  - o_grantN_cnt increments on each accept of port N.
  - o_conflict_cnt increments in each cycle where both eligN=1.
  - All counters wrap 0xFFFFFFFF->0 and clear on i_rst.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset: hold i_rst 2 cycles with both reqs valid -> both readies 0, both rsp_valid 0; first cycle after release port 0 granted.
- Single port ADD: req0 op1=10, op2=5, alu_op=4'b0000, rsp0_ready=1 -> ready0=1 that cycle; next cycle rsp0_valid=1, result=15; rsp1_valid stays 0.
- Contention: both valid every cycle; req0 SUB 10-5 (4'b1000), req1 SLT 5,10 (4'b0010); both rsp_ready=1 -> grants alternate 0,1,0,1; rsp0 results 5 and rsp1 results 1; no cycle with both readies.
- Backpressure: rsp0_ready=0 after first port 0 result (15) -> rsp0 holds 15; ready0=0 while req1 keeps getting granted every cycle; raising rsp0_ready grants port 0 in the same cycle.
- Reset mid-flight: accept req1 ADD 7+1, assert i_rst next cycle -> rsp1_valid=0, result=0 after the edge; no response for that op.
- ALU_ARB_PERF_EN: 4 contended cycles then 2 cycles port 1 alone -> grant0_cnt=2, grant1_cnt=4, conflict_cnt=4.
